data_mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction port. It accepts one read or write request at a time over a valid/ready handshake and holds a word-organised storage array. It inserts a programmable number of wait states, performs byte/halfword/word accesses with little-endian lane selection, and returns a single response per request. It sits where the CPU's memory instance is today, so the control unit can be extended to handshake-based, variable-latency memory.

---
 rtl/mem_resp_pkg.sv | 29 ++
 rtl/byte_lane_unit.sv | 50 +++++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and byte-enable helper for the data memory responder
package mem_resp_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   // Lanes touched by an access; an illegal size touches none.
   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SIZE_BYTE: be = 4'b0001 << lane;
         SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - little-endian lane merge for stores and lane extraction for loads
module byte_lane_unit
   import mem_resp_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] store_word,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [3:0]  be;
   logic [31:0] rep;
   logic [15:0] sel;

   always_comb begin
      be = byte_enable(size, lane);

      // Replicate right-justified store data so every enabled lane sees its byte.
      case (size)
         SIZE_BYTE: rep = {4{wdata[7:0]}};
         SIZE_HALF: rep = {2{wdata[15:0]}};
         default:   rep = wdata;
      endcase

      for (int i = 0; i < 4; i++) begin
         store_word[8*i +: 8] = be[i] ? rep[8*i +: 8] : old_word[8*i +: 8];
      end

      case (lane)
         2'd0:    sel = old_word[15:0];
         2'd1:    sel = old_word[23:8];
         2'd2:    sel = old_word[31:16];
         default: sel = {8'h00, old_word[31:24]};
      endcase

      case (size)
         SIZE_BYTE: load_data = {24'h0, sel[7:0]};
         SIZE_HALF: load_data = {16'h0, sel};
         SIZE_WORD: load_data = old_word;
         default:   load_data = 32'h0;
      endcase

      misalign = ((size == SIZE_HALF) && lane[0]) ||
                 ((size == SIZE_WORD) && (lane != 2'b00));
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshake memory responder with programmable wait states
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [32:0] LIMIT    = 33'(DEPTH) * 33'd4;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q;
   logic        lat_write;
   logic [1:0]  lat_size;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic [31:0] mem [DEPTH];

   logic        accept, commit;
   logic        cur_write;
   logic [1:0]  cur_size;
   logic [31:0] cur_addr, cur_wdata;
   logic [AW-1:0] word_idx;
   logic [31:0] old_word, store_word, load_data;
   logic        misalign, out_of_range, err;

   assign req_ready = (state_q == IDLE) && !reset;
   assign rsp_valid = (state_q == RESP);
   assign accept    = req_valid && req_ready;
   assign commit    = !reset && ((accept && (LATENCY == 0)) ||
                                 ((state_q == WAIT) && (cnt_q == 4'd0)));

   // With zero wait states the commit happens on the accept edge, before the latch is valid.
   assign cur_write = (state_q == IDLE) ? req_write : lat_write;
   assign cur_size  = (state_q == IDLE) ? req_size  : lat_size;
   assign cur_addr  = (state_q == IDLE) ? req_addr  : lat_addr;
   assign cur_wdata = (state_q == IDLE) ? req_wdata : lat_wdata;

   assign word_idx     = cur_addr[AW+1:2];
   assign old_word     = mem[word_idx];
   assign out_of_range = ({1'b0, cur_addr} >= LIMIT);
   assign err          = (cur_size == 2'b11) || misalign || out_of_range;

   byte_lane_unit u_lanes (
      .old_word   (old_word),
      .wdata      (cur_wdata),
      .size       (cur_size),
      .lane       (cur_addr[1:0]),
      .store_word (store_word),
      .load_data  (load_data),
      .misalign   (misalign)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (LATENCY == 0) ? RESP : WAIT;
         WAIT: if (cnt_q == 4'd0) state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= LAT_LOAD;
            lat_write <= req_write;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (commit) begin
            rsp_rdata <= (cur_write || err) ? 32'h0 : load_data;
            rsp_err   <= err;
         end else if ((state_q == RESP) && rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Storage is never cleared by reset.
   always_ff @(posedge clock) begin
      if (commit && cur_write && !err) begin
         mem[word_idx] <= store_word;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at latencies 1, 3 and 0
module tb_data_mem_responder;

   localparam int LATS [3] = '{1, 3, 0};

   logic        clock = 1'b0;
   logic        reset     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_write [3];
   logic [1:0]  req_size  [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(.DEPTH(256), .LATENCY(LATS[g])) u_dut (
         .clock     (clock),
         .reset     (reset[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_size  (req_size[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g])
      );
   end

   typedef struct packed {
      logic [31:0] rd;
      logic        e;
   } exp_t;

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        e;
   } vec_t;

   exp_t sb [$];
   vec_t tbl [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic issue(input int d, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic e);
      int n = 0;
      req_write[d] = w;
      req_size[d]  = sz;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_valid[d] = 1'b1;
      while (!req_ready[d] && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk("accept_timeout", {31'h0, req_ready[d]}, 32'h1);
      @(posedge clock);
      @(negedge clock);
      req_valid[d] = 1'b0;
      sb.push_back('{rd, e});
   endtask

   task automatic check_rsp(input int d);
      exp_t x;
      if (rsp_valid[d] && sb.size() > 0) begin
         x = sb.pop_front();
         chk("rsp_rdata", rsp_rdata[d], x.rd);
         chk("rsp_err", {31'h0, rsp_err[d]}, {31'h0, x.e});
      end else begin
         chk("rsp_missing", {31'h0, rsp_valid[d]}, 32'h1);
      end
   endtask

   task automatic collect(input int d, input int lat);
      int n = 1;
      while (!rsp_valid[d] && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk("rsp_latency", 32'(n), 32'(lat));
      check_rsp(d);
      if (rsp_ready[d]) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, total=%0d", total);
      $fatal(1);
   end

   initial begin
      int acc [4];
      int seen;
      logic [31:0] b2b_addr [4];
      logic [31:0] b2b_data [4];

      for (int d = 0; d < 3; d++) begin
         reset[d]     = 1'b1;
         req_valid[d] = 1'b0;
         req_write[d] = 1'b0;
         req_size[d]  = 2'b00;
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'h0;
         rsp_ready[d] = 1'b1;
      end

      @(negedge clock);
      chk("reset_req_ready", {31'h0, req_ready[0]}, 32'h0);
      for (int d = 0; d < 3; d++) reset[d] = 1'b0;
      @(negedge clock);
      chk("post_reset_req_ready", {31'h0, req_ready[0]}, 32'h1);
      chk("post_reset_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
      chk("post_reset_rdata", rsp_rdata[0], 32'h0);
      chk("post_reset_err", {31'h0, rsp_err[0]}, 32'h0);

      tbl.push_back('{1'b1, 2'b10, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 2'b10, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 2'b00, 32'h20,   32'hABCDEF11, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 2'b00, 32'h21,   32'hABCDEF22, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 2'b00, 32'h22,   32'hABCDEF33, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 2'b00, 32'h23,   32'hABCDEF44, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 2'b10, 32'h20,   32'h0,        32'h44332211, 1'b0});
      tbl.push_back('{1'b0, 2'b01, 32'h22,   32'h0,        32'h00004433, 1'b0});
      tbl.push_back('{1'b0, 2'b00, 32'h21,   32'h0,        32'h00000022, 1'b0});
      tbl.push_back('{1'b0, 2'b01, 32'h21,   32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b1, 2'b10, 32'h12,   32'hFFFFFFFF, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 2'b11, 32'h0,    32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b0, 2'b10, 32'h400,  32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b1, 2'b00, 32'h400,  32'h77,       32'h0,        1'b1});
      tbl.push_back('{1'b0, 2'b10, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 2'b01, 32'h12,   32'h1234CAFE, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 2'b10, 32'h10,   32'h0,        32'hCAFEBEEF, 1'b0});
      tbl.push_back('{1'b1, 2'b10, 32'h3FC,  32'hA5A5A5A5, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 2'b10, 32'h13FC, 32'h55555555, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 2'b10, 32'h3FC,  32'h0,        32'hA5A5A5A5, 1'b0});
      tbl.push_back('{1'b0, 2'b00, 32'h3FF,  32'h0,        32'h000000A5, 1'b0});
      tbl.push_back('{1'b0, 2'b10, 32'h20,   32'h0,        32'h44332211, 1'b0});

      foreach (tbl[i]) begin
         issue(0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].e);
         collect(0, LATS[0] + 1);
      end

      // Backpressure: response held while rsp_ready is low.
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, 2'b00, 32'h23, 32'h0, 32'h00000044, 1'b0);
      collect(0, LATS[0] + 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("hold_rsp_valid", {31'h0, rsp_valid[0]}, 32'h1);
         chk("hold_rdata", rsp_rdata[0], 32'h00000044);
         chk("hold_req_ready", {31'h0, req_ready[0]}, 32'h0);
      end
      rsp_ready[0] = 1'b1;
      @(negedge clock);
      chk("release_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
      chk("release_req_ready", {31'h0, req_ready[0]}, 32'h1);
      chk("release_rdata", rsp_rdata[0], 32'h0);

      // LATENCY=3: reset in the second wait cycle drops the pending store.
      issue(1, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
      collect(1, LATS[1] + 1);
      issue(1, 1'b1, 2'b10, 32'h40, 32'h12345678, 32'h0, 1'b0);
      @(negedge clock);
      reset[1] = 1'b1;
      @(negedge clock);
      chk("wait_reset_req_ready", {31'h0, req_ready[1]}, 32'h0);
      reset[1] = 1'b0;
      sb.delete();
      @(negedge clock);
      chk("after_reset_rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
      chk("after_reset_rdata", rsp_rdata[1], 32'h0);
      chk("after_reset_err", {31'h0, rsp_err[1]}, 32'h0);
      chk("after_reset_req_ready", {31'h0, req_ready[1]}, 32'h1);
      issue(1, 1'b0, 2'b10, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
      collect(1, LATS[1] + 1);

      // Reset and request in the same cycle: nothing accepted.
      reset[1]     = 1'b1;
      req_write[1] = 1'b1;
      req_size[1]  = 2'b10;
      req_addr[1]  = 32'h40;
      req_wdata[1] = 32'hFFFFFFFF;
      req_valid[1] = 1'b1;
      @(negedge clock);
      reset[1]     = 1'b0;
      req_valid[1] = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (rsp_valid[1]) seen++;
      end
      chk("reset_wins_no_rsp", 32'(seen), 32'h0);
      issue(1, 1'b0, 2'b10, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
      collect(1, LATS[1] + 1);

      // LATENCY=0: back-to-back loads every two cycles.
      issue(2, 1'b1, 2'b10, 32'h80, 32'h0BADF00D, 32'h0, 1'b0);
      collect(2, LATS[2] + 1);
      issue(2, 1'b1, 2'b10, 32'h84, 32'h600DCAFE, 32'h0, 1'b0);
      collect(2, LATS[2] + 1);
      b2b_addr = '{32'h80, 32'h84, 32'h80, 32'h84};
      b2b_data = '{32'h0BADF00D, 32'h600DCAFE, 32'h0BADF00D, 32'h600DCAFE};
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         req_write[2] = 1'b0;
         req_size[2]  = 2'b10;
         req_addr[2]  = b2b_addr[k];
         req_valid[2] = 1'b1;
         while (!req_ready[2] && n < 20) begin
            @(negedge clock);
            n++;
         end
         acc[k] = cyc;
         @(posedge clock);
         @(negedge clock);
         sb.push_back('{b2b_data[k], 1'b0});
         check_rsp(2);
      end
      req_valid[2] = 1'b0;
      @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         chk("b2b_spacing", 32'(acc[k+1] - acc[k]), 32'd2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
